// File: rtl/opp_packet_rx_if.sv
// Byte-stream receive bus carrying opponent-state frames from the network path.
interface opp_packet_rx_if;
    logic       axiiv;
    logic [7:0] axiid;
    logic       axiil;

    modport master (output axiiv, output axiid, output axiil);
    modport slave  (input  axiiv, input  axiid, input  axiil);
endinterface

// File: rtl/opp_packet_rx.sv
// Opponent-state frame receiver: parses 9-byte sync/XOR-protected frames from a
// byte stream and latches the decoded position, heading and game status.
module opp_packet_rx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned ERR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    opp_packet_rx_if.slave       rx,
    output logic [10:0]          opp_x,
    output logic [10:0]          opp_y,
    output logic [8:0]           opp_dir,
    output logic [2:0]           opp_game,
    output logic                 opp_rst,
    output logic                 frame_valid,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {StIdle, StBody, StCheck, StDrop} state_e;

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           shadow_q [1:7];
    logic [7:0]           shadow_d [1:7];
    logic [10:0]          opp_x_q, opp_y_q;
    logic [8:0]           opp_dir_q;
    logic [2:0]           opp_game_q;
    logic                 opp_rst_q;
    logic                 frame_valid_q;
    logic [ERR_WIDTH-1:0] err_q;
    logic                 commit, err_inc;
    logic [8:0]           dec_dir;
    logic                 resv_ok, frame_ok;

    // Decode the shadowed body; reserved bits must be zero for the frame to be usable.
    always_comb begin
        dec_dir  = {shadow_q[5][0], shadow_q[6]};
        resv_ok  = (shadow_q[1][7:3] == 5'd0) && (shadow_q[3][7:3] == 5'd0) &&
                   (shadow_q[5][7:1] == 7'd0) && (shadow_q[7][7:4] == 4'd0);
        frame_ok = rx.axiil && (rx.axiid == csum_q) && (dec_dir <= 9'd359) && resv_ok;
    end

    // Next-state logic; idle bus cycles leave every piece of parser state untouched.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        commit   = 1'b0;
        err_inc  = 1'b0;
        if (rx.axiiv) begin
            unique case (state_q)
                StIdle: begin
                    if (rx.axiid == SYNC_BYTE && !rx.axiil) begin
                        state_d = StBody;
                        idx_d   = 3'd1;
                        csum_d  = SYNC_BYTE;
                    end
                end
                StBody: begin
                    if (rx.axiil) begin
                        err_inc = 1'b1;
                        state_d = StIdle;
                        idx_d   = 3'd0;
                        csum_d  = 8'd0;
                    end else begin
                        shadow_d[idx_q] = rx.axiid;
                        csum_d          = csum_q ^ rx.axiid;
                        idx_d           = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = StCheck;
                    end
                end
                StCheck: begin
                    idx_d  = 3'd0;
                    csum_d = 8'd0;
                    if (frame_ok) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        err_inc = 1'b1;
                        state_d = rx.axiil ? StIdle : StDrop;
                    end
                end
                StDrop: begin
                    if (rx.axiil) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Parser state and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            csum_q  <= 8'd0;
            for (int i = 1; i <= 7; i++) shadow_q[i] <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
        end
    end

    // Output latches, commit strobe and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            opp_x_q       <= 11'd256;
            opp_y_q       <= 11'd100;
            opp_dir_q     <= 9'd0;
            opp_game_q    <= 3'd0;
            opp_rst_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= '0;
        end else begin
            frame_valid_q <= commit;
            if (commit) begin
                opp_x_q    <= {shadow_q[1][2:0], shadow_q[2]};
                opp_y_q    <= {shadow_q[3][2:0], shadow_q[4]};
                opp_dir_q  <= dec_dir;
                opp_game_q <= shadow_q[7][2:0];
                opp_rst_q  <= shadow_q[7][3];
            end
            if (err_inc && !(&err_q)) err_q <= err_q + 1'b1;
        end
    end

    assign opp_x       = opp_x_q;
    assign opp_y       = opp_y_q;
    assign opp_dir     = opp_dir_q;
    assign opp_game    = opp_game_q;
    assign opp_rst     = opp_rst_q;
    assign frame_valid = frame_valid_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_opp_packet_rx.sv
// Directed bench for opp_packet_rx: inputs driven and outputs sampled on the falling edge.
module tb_opp_packet_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opp_x, opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_game;
    logic        opp_rst;
    logic        frame_valid;
    logic [7:0]  err_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] frm [0:8];

    opp_packet_rx_if bus ();

    opp_packet_rx #(.SYNC_BYTE(8'hA5), .ERR_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus),
        .opp_x       (opp_x),
        .opp_y       (opp_y),
        .opp_dir     (opp_dir),
        .opp_game    (opp_game),
        .opp_rst     (opp_rst),
        .frame_valid (frame_valid),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic fix_chk();
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < 8; i++) c = c ^ frm[i];
        frm[8] = c;
    endtask

    task automatic make_frame(input int x, input int y, input int dir, input int game,
                              input int r);
        logic [10:0] xv, yv;
        logic [8:0]  dv;
        xv = 11'(x); yv = 11'(y); dv = 9'(dir);
        frm[0] = 8'hA5;
        frm[1] = {5'd0, xv[10:8]};
        frm[2] = xv[7:0];
        frm[3] = {5'd0, yv[10:8]};
        frm[4] = yv[7:0];
        frm[5] = {7'd0, dv[8]};
        frm[6] = dv[7:0];
        frm[7] = {4'd0, 1'(r), 3'(game)};
        fix_chk();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        @(negedge clk);
        bus.axiiv = 1'b1;
        bus.axiid = d;
        bus.axiil = l;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.axiiv = 1'b0;
            bus.axiid = 8'($urandom);
            bus.axiil = 1'($urandom);
        end
    endtask

    // Sends frm[0..nbytes-1], axiil on the final byte, optional gap between bytes.
    task automatic send_frame(input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(frm[i], i == nbytes - 1);
            if (gap > 0 && i < nbytes - 1) idle_cycles(gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.axiiv = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.axiiv = 1'b0; bus.axiid = 8'd0; bus.axiil = 1'b0;
        rst = 1'b1;
        idle_cycles(3);
        vectors++;
        if (opp_x !== 11'd256 || opp_y !== 11'd100 || opp_dir !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_pos: x=%0d y=%0d dir=%0d, want 256 100 0", opp_x, opp_y, opp_dir);
        end
        vectors++;
        if (opp_game !== 3'd0 || opp_rst !== 1'b0 || frame_valid !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_misc: game=%0d rst=%0b fv=%0b err=%0d, want 0 0 0 0",
                     opp_game, opp_rst, frame_valid, err_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_valid_frame();
        frm[0] = 8'hA5; frm[1] = 8'h01; frm[2] = 8'h2C; frm[3] = 8'h05;
        frm[4] = 8'hDC; frm[5] = 8'h01; frm[6] = 8'h0E; frm[7] = 8'h01; frm[8] = 8'h5F;
        send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b1 || opp_x !== 11'd300 || opp_y !== 11'd1500) begin
            miscompares++;
            $display("FAIL valid_commit: fv=%0b x=%0d y=%0d, want 1 300 1500", frame_valid, opp_x, opp_y);
        end
        vectors++;
        if (opp_dir !== 9'd270 || opp_game !== 3'd1 || opp_rst !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL valid_fields: dir=%0d game=%0d rst=%0b err=%0d, want 270 1 0 0",
                     opp_dir, opp_game, opp_rst, err_count);
        end
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b0 || opp_x !== 11'd300) begin
            miscompares++;
            $display("FAIL valid_pulse: fv=%0b x=%0d, want 0 300", frame_valid, opp_x);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        make_frame(300, 1500, 270, 1, 0);
        frm[8] = ~frm[8];
        send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b0 || opp_x !== 11'd256 || opp_y !== 11'd100 || opp_dir !== 9'd0 ||
            err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL bad_chk: fv=%0b x=%0d y=%0d dir=%0d err=%0d, want 0 256 100 0 1",
                     frame_valid, opp_x, opp_y, opp_dir, err_count);
        end
    endtask

    task automatic test_early_last();
        do_reset();
        make_frame(300, 1500, 270, 1, 0);
        send_frame(5, 0);
        make_frame(1000, 7, 359, 5, 1);
        send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (err_count !== 8'd1 || frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL early_last: err=%0d fv=%0b, want 1 1", err_count, frame_valid);
        end
        vectors++;
        if (opp_x !== 11'd1000 || opp_y !== 11'd7 || opp_dir !== 9'd359 || opp_game !== 3'd5 ||
            opp_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL early_follow: x=%0d y=%0d dir=%0d game=%0d rst=%0b, want 1000 7 359 5 1",
                     opp_x, opp_y, opp_dir, opp_game, opp_rst);
        end
    endtask

    task automatic test_dir_360();
        do_reset();
        make_frame(300, 1500, 360, 1, 0);
        send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b0 || opp_dir !== 9'd0 || err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL dir_360: fv=%0b dir=%0d err=%0d, want 0 0 1", frame_valid, opp_dir, err_count);
        end
    endtask

    task automatic test_reserved();
        do_reset();
        make_frame(300, 1500, 270, 1, 0);
        frm[3][7] = 1'b1;
        fix_chk();
        send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b0 || opp_y !== 11'd100 || err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL reserved: fv=%0b y=%0d err=%0d, want 0 100 1", frame_valid, opp_y, err_count);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        make_frame(300, 1500, 270, 1, 0);
        send_frame(9, 3);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b1 || opp_x !== 11'd300 || opp_y !== 11'd1500 || opp_dir !== 9'd270 ||
            opp_game !== 3'd1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL gaps: fv=%0b x=%0d y=%0d dir=%0d game=%0d err=%0d, want 1 300 1500 270 1 0",
                     frame_valid, opp_x, opp_y, opp_dir, opp_game, err_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        make_frame(12, 34, 56, 2, 0);
        send_frame(9, 0);
        make_frame(2047, 2046, 180, 7, 1);
        send_byte(frm[0], 1'b0);
        vectors++;
        if (frame_valid !== 1'b1 || opp_x !== 11'd12 || opp_y !== 11'd34 || opp_dir !== 9'd56) begin
            miscompares++;
            $display("FAIL b2b_first: fv=%0b x=%0d y=%0d dir=%0d, want 1 12 34 56",
                     frame_valid, opp_x, opp_y, opp_dir);
        end
        for (int i = 1; i < 9; i++) send_byte(frm[i], i == 8);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b1 || opp_x !== 11'd2047 || opp_y !== 11'd2046 || opp_dir !== 9'd180 ||
            opp_game !== 3'd7 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL b2b_second: fv=%0b x=%0d y=%0d dir=%0d game=%0d err=%0d, want 1 2047 2046 180 7 0",
                     frame_valid, opp_x, opp_y, opp_dir, opp_game, err_count);
        end
    endtask

    task automatic test_drop();
        do_reset();
        make_frame(500, 600, 90, 3, 0);
        send_frame(9, 0);
        // Bad checksum without axiil: parser must discard until the next last byte.
        make_frame(1, 2, 3, 4, 0);
        frm[8] = ~frm[8];
        for (int i = 0; i < 9; i++) send_byte(frm[i], 1'b0);
        make_frame(1, 2, 3, 4, 0);
        for (int i = 0; i < 8; i++) send_byte(frm[i], 1'b0);
        send_byte(8'h00, 1'b1);
        idle_cycles(1);
        vectors++;
        if (err_count !== 8'd1 || opp_x !== 11'd500 || opp_y !== 11'd600 || frame_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_hold: err=%0d x=%0d y=%0d fv=%0b, want 1 500 600 0",
                     err_count, opp_x, opp_y, frame_valid);
        end
        make_frame(700, 800, 10, 6, 0);
        send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (frame_valid !== 1'b1 || opp_x !== 11'd700 || opp_game !== 3'd6 || err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL drop_recover: fv=%0b x=%0d game=%0d err=%0d, want 1 700 6 1",
                     frame_valid, opp_x, opp_game, err_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        make_frame(300, 1500, 270, 1, 0);
        frm[8] = ~frm[8];
        for (int n = 0; n < 300; n++) send_frame(9, 0);
        idle_cycles(1);
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: err=%0d, want 255", err_count);
        end
        send_frame(9, 0);
        idle_cycles(2);
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate_hold: err=%0d, want 255", err_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        make_frame(900, 901, 45, 2, 1);
        send_frame(9, 0);
        make_frame(300, 1500, 270, 1, 0);
        for (int i = 0; i < 3; i++) send_byte(frm[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.axiiv = 1'b1; bus.axiid = frm[3]; bus.axiil = 1'b0;
        @(negedge clk);
        bus.axiiv = 1'b0;
        vectors++;
        if (opp_x !== 11'd256 || opp_y !== 11'd100 || opp_dir !== 9'd0 || opp_game !== 3'd0 ||
            opp_rst !== 1'b0 || frame_valid !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset: x=%0d y=%0d dir=%0d game=%0d rst=%0b fv=%0b err=%0d, want 256 100 0 0 0 0 0",
                     opp_x, opp_y, opp_dir, opp_game, opp_rst, frame_valid, err_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 4; i < 9; i++) send_byte(frm[i], i == 8);
        idle_cycles(1);
        vectors++;
        if (err_count !== 8'd0 || frame_valid !== 1'b0 || opp_x !== 11'd256) begin
            miscompares++;
            $display("FAIL mid_reset_tail: err=%0d fv=%0b x=%0d, want 0 0 256", err_count, frame_valid, opp_x);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_early_last();
        test_dir_360();
        test_reserved();
        test_gaps();
        test_back_to_back();
        test_drop();
        test_saturation();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/opp_packet_rx.md
OPP_PACKET_RX -- requirements
Module: opp_packet_rx

Interface
REQ-001 Parameter: SYNC_BYTE, 8'hA5, first byte of every opponent-state frame.
REQ-002 Parameter: ERR_WIDTH, 8, width of the saturating error counter.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: axiiv  input  1  byte-valid strobe from the network receive path.
REQ-006 Port: axiid  input  8  received byte; sampled only when axiiv=1.
REQ-007 Port: axiil  input  1  last-byte flag; meaningful only when axiiv=1.
REQ-008 Port: opp_x  output  11  latched opponent x position.
REQ-009 Port: opp_y  output  11  latched opponent y position.
REQ-010 Port: opp_dir  output  9  latched opponent heading, 0..359 degrees.
REQ-011 Port: opp_game  output  3  latched opponent game status.
REQ-012 Port: opp_rst  output  1  latched opponent reset request.
REQ-013 Port: frame_valid  output  1  one-cycle pulse when all opp_* outputs update.
REQ-014 Port: err_count  output  ERR_WIDTH  count of rejected frames, saturating.

Function
REQ-015 The frame SHALL be 9 bytes: B0=SYNC_BYTE, B1={5'b0,x[10:8]}, B2=x[7:0], B3={5'b0,y[10:8]}, B4=y[7:0], B5={7'b0,dir[8]}, B6=dir[7:0], B7={4'b0,rst,game[2:0]}, B8=XOR of B0..B7.
REQ-016 axiil SHALL accompany B8 only.
REQ-017 The FSM SHALL have four states: IDLE, BODY, CHECK, DROP.
REQ-018 In IDLE, a byte equal to SYNC_BYTE with axiil=0 SHALL move the FSM to BODY with byte index 1 and running XOR = SYNC_BYTE.
REQ-019 In IDLE, any other valid byte SHALL be ignored silently; if it carries axiil=1, the FSM SHALL stay in IDLE.
REQ-020 In BODY, each valid byte SHALL be stored in a shadow register by index and XORed into the running checksum; the index SHALL increment.
REQ-021 After B7 is accepted, the FSM SHALL move to CHECK.
REQ-022 In BODY, axiil=1 on any byte SHALL count one error and return the FSM to IDLE.
REQ-023 In CHECK, on the next valid byte:
- If axiil=1 and the byte equals the running XOR and decoded dir<=359, the FSM SHALL commit shadow data to the opp_* outputs and return to IDLE.
- Otherwise it SHALL count one error and go to IDLE if axiil=1, or to DROP if axiil=0.
REQ-024 Nonzero reserved bits in B1/B3/B5/B7 SHALL be treated as a checksum-equivalent error (no commit, one error).
REQ-025 In DROP, all bytes SHALL be discarded until a valid byte with axiil=1, then the FSM SHALL return to IDLE.
REQ-026 The commit SHALL occur on the clock edge after B8 is sampled; frame_valid SHALL be high for exactly that one cycle.
REQ-027 opp_* outputs SHALL hold their values between commits; a partial or rejected frame SHALL never alter them.
REQ-028 Cycles with axiiv=0 SHALL not advance state, index, or checksum, regardless of gaps.
REQ-029 err_count SHALL increment by exactly 1 per rejected frame and saturate at 2^ERR_WIDTH-1.
REQ-030 At most one error SHALL be counted per frame.
REQ-031 Back-to-back frames (a new SYNC_BYTE the cycle after B8) SHALL be accepted with no dead cycle.

Reset
REQ-032 While rst=1, the FSM SHALL be in IDLE, index=0, checksum=0, and shadow registers=0.
REQ-033 While rst=1, outputs SHALL be: opp_x=256, opp_y=100, opp_dir=0, opp_game=0, opp_rst=0, frame_valid=0, err_count=0.
REQ-034 Asserting rst mid-frame SHALL abandon the frame without counting an error; bytes after reset release SHALL be parsed from IDLE.

Verification
REQ-035 Valid frame x=300, y=1500, dir=270, game=1, rst=0 (bytes A5 01 2C 05 DC 01 0E 01 chk) -> one cycle after B8: frame_valid=1, opp_x=300, opp_y=1500, opp_dir=270, opp_game=1; err_count=0.
REQ-036 Same frame with checksum byte inverted -> frame_valid stays 0, opp_* unchanged at reset values, err_count=1.
REQ-037 Frame with axiil on B4 -> err_count=1, FSM in IDLE; an immediately following valid frame commits correctly.
REQ-038 Frame encoding dir=360 with a correct checksum -> no commit, err_count=1.
REQ-039 Valid frame with axiiv deasserted for 3 random cycles between every byte -> identical commit to the gapless case.
REQ-040 300 bad frames -> err_count=255 and held; rst mid-frame at B3 -> no error counted, all outputs at reset values.
